// File: rtl/rv_csr_file.sv
// Machine-mode CSR file: atomic read-modify-write access with a one-cycle response,
// 64-bit cycle/instret counters and exported trap state.
module rv_csr_file #(
  parameter logic [31:0] HART_ID = 32'h0,
  parameter logic [31:0] MISA    = 32'h4000_0100
) (
  input  logic        i_clk,
  input  logic        i_reset_n,
  input  logic        i_req,
  input  logic        i_flush,
  input  logic [11:0] i_idx,
  input  logic [1:0]  i_op,
  input  logic        i_sel,
  input  logic [4:0]  i_imm,
  input  logic [31:0] i_data,
  input  logic        i_instret,
  input  logic [2:0]  i_irq,
  output logic        o_ack,
  output logic [31:0] o_data,
  output logic        o_illegal,
  output logic        o_mstatus_mie,
  output logic [31:0] o_mie,
  output logic [31:0] o_mtvec,
  output logic [31:0] o_mepc
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MIE       = 12'h304;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MTVAL     = 12'h343;
  localparam logic [11:0] A_MIP       = 12'h344;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        mst_mie, mst_mpie;
  logic [31:0] mie_q, mtvec_q, mscratch_q, mepc_q, mcause_q, mtval_q;
  logic [63:0] mcycle_q, minstret_q;

  logic [31:0] src, old_val, new_val;
  logic        hit, we, illegal, accept, wr;

  assign src = i_sel ? {27'b0, i_imm} : i_data;

  always_comb begin
    old_val = '0;
    hit     = 1'b1;
    case (i_idx)
      A_MSTATUS:   old_val = {19'b0, 2'b11, 3'b0, mst_mpie, 3'b0, mst_mie, 3'b0};
      A_MISA:      old_val = MISA;
      A_MIE:       old_val = mie_q;
      A_MTVEC:     old_val = mtvec_q;
      A_MSCRATCH:  old_val = mscratch_q;
      A_MEPC:      old_val = mepc_q;
      A_MCAUSE:    old_val = mcause_q;
      A_MTVAL:     old_val = mtval_q;
      A_MIP:       old_val = {20'b0, i_irq[2], 3'b0, i_irq[1], 3'b0, i_irq[0], 3'b0};
      A_MCYCLE:    old_val = mcycle_q[31:0];
      A_MCYCLEH:   old_val = mcycle_q[63:32];
      A_MINSTRET:  old_val = minstret_q[31:0];
      A_MINSTRETH: old_val = minstret_q[63:32];
      A_MHARTID:   old_val = HART_ID;
      default:     hit = 1'b0;
    endcase
  end

  always_comb begin
    case (i_op)
      2'b01:   new_val = src;
      2'b10:   new_val = old_val | src;
      2'b11:   new_val = old_val & ~src;
      default: new_val = old_val;
    endcase
  end

  // Set/clear with a zero source is a pure read and so is allowed in read-only space.
  assign we      = (i_op == 2'b01) || (i_op[1] && (src != 32'h0));
  assign illegal = !hit || (we && (i_idx[11:10] == 2'b11));
  assign accept  = i_req && !i_flush;
  assign wr      = accept && we && !illegal;

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mst_mie    <= 1'b0;
      mst_mpie   <= 1'b0;
      mie_q      <= '0;
      mtvec_q    <= '0;
      mscratch_q <= '0;
      mepc_q     <= '0;
      mcause_q   <= '0;
      mtval_q    <= '0;
    end else if (wr) begin
      case (i_idx)
        A_MSTATUS: begin
          mst_mie  <= new_val[3];
          mst_mpie <= new_val[7];
        end
        A_MIE:      mie_q      <= new_val & 32'h0000_0888;
        A_MTVEC:    mtvec_q    <= new_val & 32'hFFFF_FFFC;
        A_MSCRATCH: mscratch_q <= new_val;
        A_MEPC:     mepc_q     <= new_val & 32'hFFFF_FFFC;
        A_MCAUSE:   mcause_q   <= new_val;
        A_MTVAL:    mtval_q    <= new_val;
        default:    ;
      endcase
    end
  end

  // A write to either half freezes the whole counter for that cycle (no carry, no tick).
  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      mcycle_q   <= '0;
      minstret_q <= '0;
    end else begin
      if (wr && (i_idx == A_MCYCLE))        mcycle_q[31:0]  <= new_val;
      else if (wr && (i_idx == A_MCYCLEH))  mcycle_q[63:32] <= new_val;
      else                                  mcycle_q        <= mcycle_q + 64'd1;

      if (wr && (i_idx == A_MINSTRET))       minstret_q[31:0]  <= new_val;
      else if (wr && (i_idx == A_MINSTRETH)) minstret_q[63:32] <= new_val;
      else if (i_instret)                    minstret_q        <= minstret_q + 64'd1;
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      o_ack     <= 1'b0;
      o_data    <= '0;
      o_illegal <= 1'b0;
    end else begin
      o_ack     <= accept;
      o_data    <= (accept && !illegal) ? old_val : 32'h0;
      o_illegal <= accept && illegal;
    end
  end

  assign o_mstatus_mie = mst_mie;
  assign o_mie         = mie_q;
  assign o_mtvec       = mtvec_q;
  assign o_mepc        = mepc_q;

endmodule

// File: tb/tb_rv_csr_file.sv
// Bench for rv_csr_file: vector table feeding a response scoreboard, plus hand
// sequences for exported state and asynchronous reset.
module tb_rv_csr_file;

  logic        i_clk = 1'b0;
  logic        i_reset_n = 1'b0;
  logic        i_req = 1'b0, i_flush = 1'b0, i_sel = 1'b0, i_instret = 1'b0;
  logic [11:0] i_idx = '0;
  logic [1:0]  i_op = '0;
  logic [4:0]  i_imm = '0;
  logic [31:0] i_data = '0;
  logic [2:0]  i_irq = '0;
  logic        o_ack, o_illegal, o_mstatus_mie;
  logic [31:0] o_data, o_mie, o_mtvec, o_mepc;

  rv_csr_file dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n), .i_req(i_req), .i_flush(i_flush),
    .i_idx(i_idx), .i_op(i_op), .i_sel(i_sel), .i_imm(i_imm), .i_data(i_data),
    .i_instret(i_instret), .i_irq(i_irq), .o_ack(o_ack), .o_data(o_data),
    .o_illegal(o_illegal), .o_mstatus_mie(o_mstatus_mie), .o_mie(o_mie),
    .o_mtvec(o_mtvec), .o_mepc(o_mepc)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [11:0] idx;
    logic [1:0]  op;
    logic        sel;
    logic [4:0]  imm;
    logic [31:0] data;
    logic        instret;
    logic [2:0]  irq;
    logic        flush;
    logic [31:0] exp;
    logic [31:0] mask;
    logic        ill;
  } vec_t;

  typedef struct {
    logic [31:0] data;
    logic [31:0] mask;
    logic        ill;
    int          cyc;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];
  int   cyc = 0;
  int   n_vec = 0;
  int   n_miss = 0;

  always @(posedge i_clk) cyc++;

  always @(negedge i_clk) begin
    exp_t e;
    if (o_ack) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_miss++;
        $display("FAIL unexpected_ack cyc=%0d data=%h", cyc, o_data);
      end else begin
        e = sb.pop_front();
        if (e.cyc != cyc || (o_data & e.mask) != (e.data & e.mask) || o_illegal != e.ill) begin
          n_miss++;
          $display("FAIL resp cyc=%0d (exp %0d) data=%h ill=%b, exp data=%h ill=%b",
                   cyc, e.cyc, o_data, o_illegal, e.data, e.ill);
        end
      end
    end else if (sb.size() != 0 && sb[0].cyc <= cyc) begin
      n_vec++;
      n_miss++;
      e = sb.pop_front();
      $display("FAIL missing_ack cyc=%0d exp data=%h", cyc, e.data);
    end
  end

  function automatic vec_t mk(logic [11:0] idx, logic [1:0] op, logic sel, logic [4:0] imm,
                              logic [31:0] data, logic [31:0] exp, logic ill,
                              logic instret = 1'b0, logic [2:0] irq = 3'b0,
                              logic flush = 1'b0, logic [31:0] mask = 32'hFFFF_FFFF);
    vec_t v;
    v.idx = idx; v.op = op; v.sel = sel; v.imm = imm; v.data = data; v.exp = exp;
    v.ill = ill; v.instret = instret; v.irq = irq; v.flush = flush; v.mask = mask;
    return v;
  endfunction

  task automatic req(input vec_t v);
    @(negedge i_clk);
    i_req = 1'b1; i_idx = v.idx; i_op = v.op; i_sel = v.sel; i_imm = v.imm;
    i_data = v.data; i_instret = v.instret; i_irq = v.irq; i_flush = v.flush;
    if (!v.flush) sb.push_back('{data: v.exp, mask: v.mask, ill: v.ill, cyc: cyc + 1});
  endtask

  task automatic idle();
    @(negedge i_clk);
    i_req = 1'b0; i_instret = 1'b0; i_flush = 1'b0; i_op = 2'b00;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  initial begin
    // mscratch basics and flush behaviour
    vt.push_back(mk(12'h340, 2'b01, 0, 0, 32'hDEAD_BEEF, 32'h0, 0));
    vt.push_back(mk(12'h340, 2'b10, 0, 0, 32'h0, 32'hDEAD_BEEF, 0));
    vt.push_back(mk(12'h340, 2'b00, 0, 0, 32'h0, 32'hDEAD_BEEF, 0));
    vt.push_back(mk(12'h340, 2'b01, 0, 0, 32'h1111, 32'h0, 0, 0, 0, 1));
    vt.push_back(mk(12'h340, 2'b00, 0, 0, 32'h0, 32'hDEAD_BEEF, 0));
    vt.push_back(mk(12'h340, 2'b01, 0, 0, 32'h2222, 32'hDEAD_BEEF, 0));
    vt.push_back(mk(12'h340, 2'b01, 0, 0, 32'h3333, 32'h0, 0, 0, 0, 1));
    vt.push_back(mk(12'h340, 2'b00, 0, 0, 32'h0, 32'h2222, 0));
    // mstatus, mtvec, illegal, misa, mie, mepc, mcause, mtval, mip
    vt.push_back(mk(12'h300, 2'b10, 1, 8, 32'h0, 32'h1800, 0));
    vt.push_back(mk(12'h300, 2'b11, 1, 8, 32'h0, 32'h1808, 0));
    vt.push_back(mk(12'h300, 2'b00, 0, 0, 32'h0, 32'h1800, 0));
    vt.push_back(mk(12'h305, 2'b01, 0, 0, 32'h8000_0003, 32'h0, 0));
    vt.push_back(mk(12'h305, 2'b00, 0, 0, 32'h0, 32'h8000_0000, 0));
    vt.push_back(mk(12'hF14, 2'b01, 0, 0, 32'h1, 32'h0, 1));
    vt.push_back(mk(12'h7C0, 2'b00, 0, 0, 32'h0, 32'h0, 1));
    vt.push_back(mk(12'hF14, 2'b10, 0, 0, 32'h0, 32'h0, 0));
    vt.push_back(mk(12'h301, 2'b01, 0, 0, 32'h0, 32'h4000_0100, 0));
    vt.push_back(mk(12'h301, 2'b00, 0, 0, 32'h0, 32'h4000_0100, 0));
    vt.push_back(mk(12'h304, 2'b01, 0, 0, 32'hFFFF_FFFF, 32'h0, 0));
    vt.push_back(mk(12'h304, 2'b00, 0, 0, 32'h0, 32'h0000_0888, 0));
    vt.push_back(mk(12'h341, 2'b01, 0, 0, 32'h1235, 32'h0, 0));
    vt.push_back(mk(12'h341, 2'b11, 1, 0, 32'h0, 32'h1234, 0));
    vt.push_back(mk(12'h342, 2'b01, 0, 0, 32'h8000_000B, 32'h0, 0));
    vt.push_back(mk(12'h342, 2'b10, 0, 0, 32'h10, 32'h8000_000B, 0));
    vt.push_back(mk(12'h342, 2'b00, 0, 0, 32'h0, 32'h8000_001B, 0));
    vt.push_back(mk(12'h343, 2'b01, 0, 0, 32'hFFFF_FFFF, 32'h0, 0));
    vt.push_back(mk(12'h343, 2'b11, 0, 0, 32'h0F0, 32'hFFFF_FFFF, 0));
    vt.push_back(mk(12'h343, 2'b00, 0, 0, 32'h0, 32'hFFFF_FF0F, 0));
    vt.push_back(mk(12'h344, 2'b00, 0, 0, 32'h0, 32'h0000_0808, 0, 0, 3'b101));
    vt.push_back(mk(12'h344, 2'b01, 0, 0, 32'hFFFF_FFFF, 32'h0000_0080, 0, 0, 3'b010));
    // mcycle carry and half-write freeze (old mcycle unknown: masked)
    vt.push_back(mk(12'hB00, 2'b01, 0, 0, 32'hFFFF_FFFE, 32'h0, 0, 0, 0, 0, 32'h0));
    vt.push_back(mk(12'hB00, 2'b00, 0, 0, 32'h0, 32'hFFFF_FFFE, 0));
    vt.push_back(mk(12'hB00, 2'b00, 0, 0, 32'h0, 32'hFFFF_FFFF, 0));
    vt.push_back(mk(12'hB80, 2'b00, 0, 0, 32'h0, 32'h1, 0));
    vt.push_back(mk(12'hB00, 2'b00, 0, 0, 32'h0, 32'h1, 0));
    vt.push_back(mk(12'hB00, 2'b01, 0, 0, 32'h10, 32'h2, 0));
    vt.push_back(mk(12'hB80, 2'b01, 0, 0, 32'h5, 32'h1, 0));
    vt.push_back(mk(12'hB00, 2'b00, 0, 0, 32'h0, 32'h10, 0));
    vt.push_back(mk(12'hB80, 2'b00, 0, 0, 32'h0, 32'h5, 0));
    // minstret: write wins over same-cycle retire, carry, high-half write
    vt.push_back(mk(12'hB02, 2'b01, 0, 0, 32'h100, 32'h0, 0, 1));
    vt.push_back(mk(12'hB02, 2'b00, 0, 0, 32'h0, 32'h100, 0, 0));
    vt.push_back(mk(12'hB02, 2'b00, 0, 0, 32'h0, 32'h100, 0, 1));
    vt.push_back(mk(12'hB02, 2'b00, 0, 0, 32'h0, 32'h101, 0, 0));
    vt.push_back(mk(12'hB02, 2'b01, 0, 0, 32'hFFFF_FFFF, 32'h101, 0, 0));
    vt.push_back(mk(12'hB82, 2'b00, 0, 0, 32'h0, 32'h0, 0, 1));
    vt.push_back(mk(12'hB82, 2'b00, 0, 0, 32'h0, 32'h1, 0, 0));
    vt.push_back(mk(12'hB02, 2'b00, 0, 0, 32'h0, 32'h0, 0, 0));
    vt.push_back(mk(12'hB82, 2'b01, 0, 0, 32'h7, 32'h1, 0, 1));
    vt.push_back(mk(12'hB02, 2'b00, 0, 0, 32'h0, 32'h0, 0, 0));
    vt.push_back(mk(12'hB82, 2'b00, 0, 0, 32'h0, 32'h7, 0, 0));

    repeat (3) @(negedge i_clk);
    chk("rst_ack", {31'b0, o_ack}, 32'h0);
    chk("rst_data", o_data, 32'h0);
    chk("rst_illegal", {31'b0, o_illegal}, 32'h0);
    chk("rst_mie_bit", {31'b0, o_mstatus_mie}, 32'h0);
    chk("rst_mie", o_mie, 32'h0);
    chk("rst_mtvec", o_mtvec, 32'h0);
    chk("rst_mepc", o_mepc, 32'h0);
    i_reset_n = 1'b1;

    foreach (vt[i]) req(vt[i]);
    idle();

    chk("exp_mtvec", o_mtvec, 32'h8000_0000);
    chk("exp_mie", o_mie, 32'h0000_0888);
    chk("exp_mepc", o_mepc, 32'h0000_1234);

    req(mk(12'h300, 2'b10, 1, 8, 32'h0, 32'h1800, 0));
    @(posedge i_clk); #1;
    chk("mstatus_mie_set", {31'b0, o_mstatus_mie}, 32'h1);
    req(mk(12'h300, 2'b11, 1, 8, 32'h0, 32'h1808, 0));
    @(posedge i_clk); #1;
    chk("mstatus_mie_clr", {31'b0, o_mstatus_mie}, 32'h0);
    idle();

    for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge i_clk);
    chk("sb_drained", sb.size(), 32'h0);

    // async reset drops a pending ack immediately
    @(negedge i_clk);
    i_req = 1'b1; i_idx = 12'h340; i_op = 2'b01; i_sel = 1'b0; i_data = 32'h5;
    @(posedge i_clk); #1;
    chk("pre_rst_ack", {31'b0, o_ack}, 32'h1);
    i_req = 1'b0;
    #1 i_reset_n = 1'b0;
    #1;
    chk("async_rst_ack", {31'b0, o_ack}, 32'h0);
    chk("async_rst_data", o_data, 32'h0);
    chk("async_rst_mtvec", o_mtvec, 32'h0);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    req(mk(12'h340, 2'b00, 0, 0, 32'h0, 32'h0, 0));
    req(mk(12'hB02, 2'b00, 0, 0, 32'h0, 32'h0, 0));
    idle();
    for (int k = 0; k < 5 && sb.size() != 0; k++) @(negedge i_clk);
    chk("sb_drained_end", sb.size(), 32'h0);
    repeat (2) @(negedge i_clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
